pipe_mem_access: RTL and testbench

//  MEM-stage consumer of the EXE/MEM pipeline register. Turns mwreg/mm2reg/mwmem/malu/mb/mrn

---
 rtl/pipe_mem_access_pkg.sv | 24 ++
 rtl/pipe_mem_access_mwreg.sv | 55 +++++
 rtl/pipe_mem_access.sv | 130 +++++++++++++
 tb/tb_pipe_mem_access.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mem_access_pkg.sv
// Shared types and defaults for the MEM-stage data-memory access block.
// Holds the FSM state encoding and the decode helpers used by the top and the bench.
package pipe_mem_access_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int RN_W_DEF     = 5;
  localparam int MAX_WAIT_DEF = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Any load or store needs the data-memory port.
  function automatic logic is_access(input logic m2reg, input logic wmem);
    return m2reg | wmem;
  endfunction

  // Load-and-store together is executed as a store, so WB never selects memory data.
  function automatic logic wb_mem_sel(input logic m2reg, input logic wmem);
    return m2reg & ~wmem;
  endfunction

endpackage

// File: rtl/pipe_mem_access_mwreg.sv
// MEM/WB pipeline register. A bubble clears the control bits and leaves the
// data fields holding their previous contents.
module pipe_mwreg
  import pipe_mem_access_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RN_W   = RN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble_i,
  input  logic              wreg_i,
  input  logic              m2reg_i,
  input  logic [DATA_W-1:0] mo_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [RN_W-1:0]   rn_i,
  output logic              wreg_o,
  output logic              m2reg_o,
  output logic [DATA_W-1:0] mo_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [RN_W-1:0]   rn_o
);

  logic              wreg_q;
  logic              m2reg_q;
  logic [DATA_W-1:0] mo_q;
  logic [DATA_W-1:0] alu_q;
  logic [RN_W-1:0]   rn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
      mo_q    <= '0;
      alu_q   <= '0;
      rn_q    <= '0;
    end else if (bubble_i) begin
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
    end else begin
      wreg_q  <= wreg_i;
      m2reg_q <= m2reg_i;
      mo_q    <= mo_i;
      alu_q   <= alu_i;
      rn_q    <= rn_i;
    end
  end

  assign wreg_o  = wreg_q;
  assign m2reg_o = m2reg_q;
  assign mo_o    = mo_q;
  assign alu_o   = alu_q;
  assign rn_o    = rn_q;

endmodule

// File: rtl/pipe_mem_access.sv
// MEM stage: turns the EXE/MEM register into a req/ack data-memory transaction,
// stalls upstream while it waits, and abandons an access after MAX_WAIT waits.
module pipe_mem_access
  import pipe_mem_access_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RN_W     = RN_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic              mwmem,
  input  logic [DATA_W-1:0] malu,
  input  logic [DATA_W-1:0] mb,
  input  logic [RN_W-1:0]   mrn,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              mem_stall,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [DATA_W-1:0] wmo,
  output logic [DATA_W-1:0] walu,
  output logic [RN_W-1:0]   wrn,
  output logic              mem_err
);

  localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               acc;
  logic               ack_v;
  logic               stall;
  logic               bubble;
  logic [DATA_W-1:0]  mo_in;

  assign acc      = is_access(mm2reg, mwmem);
  // Reset drops any outstanding request immediately, not at the next edge.
  assign dm_req   = acc & ~clr;
  assign dm_we    = mwmem & dm_req;
  assign dm_addr  = malu;
  assign dm_wdata = mb;
  assign ack_v    = dm_ack & dm_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc && !ack_v) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          state_d = ST_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (ack_v) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q < CNT_MAX) begin
          stall  = 1'b1;
          bubble = 1'b1;
          cnt_d  = cnt_q + CNT_ONE;
        end else begin
          // Timeout: squash the instruction and release the pipeline.
          err_d   = 1'b1;
          bubble  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (clr) begin
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_stall = stall;
  assign mem_err   = err_q;
  assign mo_in     = acc ? dm_rdata : '0;

  pipe_mwreg #(
    .DATA_W (DATA_W),
    .RN_W   (RN_W)
  ) u_mwreg (
    .clk      (clk),
    .rst      (clr),
    .bubble_i (bubble),
    .wreg_i   (mwreg),
    .m2reg_i  (wb_mem_sel(mm2reg, mwmem)),
    .mo_i     (mo_in),
    .alu_i    (malu),
    .rn_i     (mrn),
    .wreg_o   (wwreg),
    .m2reg_o  (wm2reg),
    .mo_o     (wmo),
    .alu_o    (walu),
    .rn_o     (wrn)
  );

endmodule

// File: tb/tb_pipe_mem_access.sv
// Bench for pipe_mem_access: directed accesses with a cycle-level reference model
// and hand-computed checkpoints.
module tb_pipe_mem_access;

  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        mwreg = 1'b0, mm2reg = 1'b0, mwmem = 1'b0;
  logic [31:0] malu = '0, mb = '0, dm_rdata = '0;
  logic [4:0]  mrn = '0;
  logic        dm_ack = 1'b0;
  logic        dm_req, dm_we, mem_stall, wwreg, wm2reg, mem_err;
  logic [31:0] dm_addr, dm_wdata, wmo, walu;
  logic [4:0]  wrn;

  int n_checks = 0;
  int n_err = 0;
  bit run = 1'b0;

  pipe_mem_access #(.DATA_W(32), .RN_W(5), .MAX_WAIT(MW)) dut (
    .clk(clk), .clr(clr), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .malu(malu), .mb(mb), .mrn(mrn), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_stall(mem_stall), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo),
    .walu(walu), .wrn(wrn), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: how many stall cycles the current access has spent, the sticky
  // error, and what the WB register should hold.
  int          m_stalls = 0;
  bit          m_err = 1'b0;
  logic        m_wreg = 1'b0, m_m2reg = 1'b0;
  logic [31:0] m_mo = '0, m_alu = '0;
  logic [4:0]  m_rn = '0;
  bit          m_mo_known = 1'b1;
  logic        e_acc, e_stall, e_bub;

  always @(negedge clk) begin
    if (run) begin
      if (clr) begin
        check("rst dm_req", 64'(dm_req), 64'd0);
        check("rst mem_stall", 64'(mem_stall), 64'd0);
        check("rst wwreg", 64'(wwreg), 64'd0);
        check("rst wm2reg", 64'(wm2reg), 64'd0);
        check("rst wmo", 64'(wmo), 64'd0);
        check("rst walu", 64'(walu), 64'd0);
        check("rst wrn", 64'(wrn), 64'd0);
        check("rst mem_err", 64'(mem_err), 64'd0);
        m_stalls = 0; m_err = 1'b0; m_wreg = 1'b0; m_m2reg = 1'b0;
        m_mo = '0; m_alu = '0; m_rn = '0; m_mo_known = 1'b1;
      end else begin
        check("wwreg", 64'(wwreg), 64'(m_wreg));
        check("wm2reg", 64'(wm2reg), 64'(m_m2reg));
        if (m_mo_known) check("wmo", 64'(wmo), 64'(m_mo));
        check("walu", 64'(walu), 64'(m_alu));
        check("wrn", 64'(wrn), 64'(m_rn));
        check("mem_err", 64'(mem_err), 64'(m_err));
        e_acc = mm2reg | mwmem;
        check("dm_req", 64'(dm_req), 64'(e_acc));
        if (e_acc) check("dm_we", 64'(dm_we), 64'(mwmem));
        check("dm_addr", 64'(dm_addr), 64'(malu));
        check("dm_wdata", 64'(dm_wdata), 64'(mb));
        e_stall = 1'b0;
        e_bub = 1'b0;
        if (e_acc && !dm_ack) begin
          e_bub = 1'b1;
          if (m_stalls < MW) begin
            e_stall = 1'b1;
            m_stalls++;
          end else begin
            m_err = 1'b1;
            m_stalls = 0;
          end
        end else begin
          m_stalls = 0;
        end
        check("mem_stall", 64'(mem_stall), 64'(e_stall));
        if (e_bub) begin
          m_wreg = 1'b0;
          m_m2reg = 1'b0;
        end else begin
          m_wreg = mwreg;
          m_m2reg = mm2reg && !mwmem;
          m_alu = malu;
          m_rn = mrn;
          if (!e_acc) begin
            m_mo = '0; m_mo_known = 1'b1;
          end else if (mwmem) begin
            m_mo_known = 1'b0;
          end else begin
            m_mo = dm_rdata; m_mo_known = 1'b1;
          end
        end
      end
    end
  end

  // Holds one instruction in EXE/MEM; dm_ack rises after 'delay' no-ack cycles,
  // delay<0 means never. Returns observed stall count, bubble count and port samples.
  task automatic run_op(input logic wr, input logic m2r, input logic wm,
                        input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                        input int delay, input logic [31:0] rd,
                        output int stalls, output int bubbles, output logic we0,
                        output logic [31:0] wd0, output bit addr_stable);
    int ncyc;
    logic [31:0] a0;
    ncyc = (delay < 0) ? MW + 1 : delay + 1;
    mwreg = wr; mm2reg = m2r; mwmem = wm; malu = alu; mb = b; mrn = rn; dm_rdata = rd;
    stalls = 0; bubbles = 0; addr_stable = 1'b1; a0 = '0; we0 = 1'b0; wd0 = '0;
    for (int k = 0; k < ncyc; k++) begin
      dm_ack = (k == delay);
      @(negedge clk);
      if (k == 0) begin
        a0 = dm_addr; we0 = dm_we; wd0 = dm_wdata;
      end else begin
        if (dm_addr !== a0) addr_stable = 1'b0;
        if (wwreg === 1'b0) bubbles++;
      end
      if (mem_stall === 1'b1) stalls++;
      @(posedge clk); #1;
    end
    dm_ack = 1'b0;
  endtask

  task automatic nop();
    mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0; malu = '0; mb = '0; mrn = '0;
    dm_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  int st, bb;
  logic we0;
  logic [31:0] wd0;
  bit stab;

  initial begin
    repeat (2) @(posedge clk);
    #1 run = 1'b1;
    @(negedge clk);
    check("init wwreg", 64'(wwreg), 64'd0);
    check("init mem_err", 64'(mem_err), 64'd0);
    @(posedge clk); #1 clr = 1'b0;

    // ALU op
    run_op(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd8, 0, 32'h0, st, bb, we0, wd0, stab);
    check("alu stalls", 64'(st), 64'd0);
    nop(); @(negedge clk);
    check("alu wwreg", 64'(wwreg), 64'd1);
    check("alu walu", 64'(walu), 64'h1234);
    check("alu wrn", 64'(wrn), 64'd8);
    @(posedge clk); #1;

    // zero-wait load
    run_op(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd3, 0, 32'hCAFE, st, bb, we0, wd0, stab);
    check("ld0 stalls", 64'(st), 64'd0);
    nop(); @(negedge clk);
    check("ld0 wm2reg", 64'(wm2reg), 64'd1);
    check("ld0 wmo", 64'(wmo), 64'hCAFE);
    @(posedge clk); #1;

    // load, ack after 3 waits
    run_op(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd5, 3, 32'h5A5A, st, bb, we0, wd0, stab);
    check("ld3 stalls", 64'(st), 64'd3);
    check("ld3 bubbles", 64'(bb), 64'd3);
    check("ld3 addr stable", 64'(stab), 64'd1);
    nop(); @(negedge clk);
    check("ld3 wmo", 64'(wmo), 64'h5A5A);
    check("ld3 wwreg", 64'(wwreg), 64'd1);
    @(posedge clk); #1;

    // store, ack after 2 waits
    run_op(1'b0, 1'b0, 1'b1, 32'h80, 32'hBEEF, 5'd0, 2, 32'h0, st, bb, we0, wd0, stab);
    check("st stalls", 64'(st), 64'd2);
    check("st dm_we", 64'(we0), 64'd1);
    check("st dm_wdata", 64'(wd0), 64'hBEEF);
    nop(); @(negedge clk);
    check("st wwreg", 64'(wwreg), 64'd0);
    @(posedge clk); #1;

    // load+store together behaves as a store
    run_op(1'b1, 1'b1, 1'b1, 32'h90, 32'h77, 5'd6, 1, 32'h1, st, bb, we0, wd0, stab);
    check("ldst dm_we", 64'(we0), 64'd1);
    nop(); @(negedge clk);
    check("ldst wm2reg", 64'(wm2reg), 64'd0);
    check("ldst wwreg", 64'(wwreg), 64'd1);
    @(posedge clk); #1;

    // back-to-back loads
    run_op(1'b1, 1'b1, 1'b0, 32'hA0, 32'h0, 5'd3, 1, 32'h1111, st, bb, we0, wd0, stab);
    run_op(1'b1, 1'b1, 1'b0, 32'hA4, 32'h0, 5'd4, 0, 32'h2222, st, bb, we0, wd0, stab);
    check("b2b stalls", 64'(st), 64'd0);
    nop(); @(negedge clk);
    check("b2b wmo", 64'(wmo), 64'h2222);
    check("b2b wrn", 64'(wrn), 64'd4);
    @(posedge clk); #1;

    // ack exactly at the timeout cycle is accepted
    run_op(1'b1, 1'b1, 1'b0, 32'hB0, 32'h0, 5'd7, MW, 32'h7777, st, bb, we0, wd0, stab);
    check("ackmax stalls", 64'(st), 64'd15);
    nop(); @(negedge clk);
    check("ackmax wmo", 64'(wmo), 64'h7777);
    check("ackmax wwreg", 64'(wwreg), 64'd1);
    check("ackmax mem_err", 64'(mem_err), 64'd0);
    @(posedge clk); #1;

    // timeout
    run_op(1'b1, 1'b1, 1'b0, 32'hC0, 32'h0, 5'd9, -1, 32'h9999, st, bb, we0, wd0, stab);
    check("tmo stalls", 64'(st), 64'd15);
    nop(); @(negedge clk);
    check("tmo wwreg", 64'(wwreg), 64'd0);
    check("tmo mem_err", 64'(mem_err), 64'd1);
    @(posedge clk); #1;
    run_op(1'b1, 1'b1, 1'b0, 32'hC4, 32'h0, 5'd10, 0, 32'hABCD, st, bb, we0, wd0, stab);
    nop(); @(negedge clk);
    check("post-tmo wmo", 64'(wmo), 64'hABCD);
    check("post-tmo mem_err", 64'(mem_err), 64'd1);
    @(posedge clk); #1;

    // reset asserted in the middle of a wait
    mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0; malu = 32'hD0; mrn = 5'd11; dm_ack = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("midwait dm_req before", 64'(dm_req), 64'd1);
    clr = 1'b1;
    #1;
    check("midwait dm_req", 64'(dm_req), 64'd0);
    check("midwait mem_stall", 64'(mem_stall), 64'd0);
    @(negedge clk);
    check("midwait mem_err", 64'(mem_err), 64'd0);
    check("midwait wwreg", 64'(wwreg), 64'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    nop();
    run_op(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd2, 0, 32'h0, st, bb, we0, wd0, stab);
    nop(); @(negedge clk);
    check("post-rst walu", 64'(walu), 64'h55);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
